// File: rtl/i2c_master_slave_pair.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_master_slave_pair
//  Brief    : Single-byte I2C master engine plus one addressed slave engine
//             sharing an internal wired-AND SDA line.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_master_slave_pair #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1011001
) (
    input  logic       i_sclk,
    input  logic       i_rst_n,
    input  logic [6:0] i_address_in,
    input  logic       i_address_r_w,
    input  logic [7:0] i_sdata_in,
    input  logic [7:0] i_data_out,
    output logic       o_sclk,
    output logic       o_sdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic [7:0] o_rdata,
    output logic [7:0] o_slave_rdata,
    output logic       o_slave_valid
);

    typedef enum logic [2:0] {
        M_IDLE, M_START, M_ADDR, M_AACK, M_DATA, M_DACK, M_STOP
    } m_state_t;

    typedef enum logic [2:0] {
        S_WAIT, S_ADDR, S_AACK, S_DATA, S_DACK
    } s_state_t;

    // ---------------- master registers ----------------
    m_state_t   r_m_state;
    m_state_t   w_m_next;
    logic       r_phase;        // 0 = L half of a bit slot, 1 = H half
    logic [2:0] r_m_bit;
    logic [7:0] r_m_byte;       // {address, r/w}
    logic       r_m_rw;
    logic [7:0] r_m_wdata;
    logic [7:0] r_m_rx;
    logic [7:0] r_rdata;
    logic       r_ack_err;
    logic       r_done;
    logic       r_rearm;
    logic       w_req;
    logic       w_scl;
    logic       w_m_sda;
    logic       w_sda;

    // ---------------- slave registers ----------------
    s_state_t   r_s_state;
    s_state_t   w_s_next;
    logic       r_s_sda;
    logic [7:0] r_s_sr;
    logic [2:0] r_s_cnt;
    logic       r_s_rw;
    logic [7:0] r_s_tx;
    logic [7:0] r_s_rdata;
    logic       r_s_valid;
    logic       r_scl_q;
    logic       r_sda_q;
    logic       w_start;
    logic       w_stop;
    logic       w_rise;
    logic [7:0] w_s_byte;

    assign w_req    = (r_m_state == M_IDLE) && r_rearm && (i_address_in != 7'd0);
    assign w_sda    = w_m_sda & r_s_sda;
    assign w_start  = r_scl_q & w_scl & r_sda_q & ~w_sda;
    assign w_stop   = r_scl_q & w_scl & ~r_sda_q & w_sda;
    assign w_rise   = w_scl & ~r_scl_q;
    assign w_s_byte = {r_s_sr[6:0], w_sda};

    assign o_sclk        = w_scl;
    assign o_sdata       = w_sda;
    assign o_busy        = (r_m_state != M_IDLE);
    assign o_done        = r_done;
    assign o_ack_err     = r_ack_err;
    assign o_rdata       = r_rdata;
    assign o_slave_rdata = r_s_rdata;
    assign o_slave_valid = r_s_valid;

    // Master next state and bus drive; SCL follows the slot phase outside IDLE/START.
    // In AACK the master releases SDA, so the bus level there is the slave's drive.
    always_comb begin
        w_m_next = r_m_state;
        w_scl    = 1'b1;
        w_m_sda  = 1'b1;
        case (r_m_state)
            M_IDLE:  if (w_req) w_m_next = M_START;
            M_START: begin
                w_m_sda  = 1'b0;
                w_m_next = M_ADDR;
            end
            M_ADDR: begin
                w_scl   = r_phase;
                w_m_sda = r_m_byte[3'd7 - r_m_bit];
                if (r_phase && (r_m_bit == 3'd7)) w_m_next = M_AACK;
            end
            M_AACK: begin
                w_scl = r_phase;
                if (r_phase) w_m_next = r_s_sda ? M_STOP : M_DATA;
            end
            M_DATA: begin
                w_scl   = r_phase;
                w_m_sda = r_m_rw ? 1'b1 : r_m_wdata[3'd7 - r_m_bit];
                if (r_phase && (r_m_bit == 3'd7)) w_m_next = M_DACK;
            end
            M_DACK: begin
                w_scl = r_phase;
                if (r_phase) w_m_next = M_STOP;
            end
            M_STOP: begin
                w_scl   = r_phase;
                w_m_sda = 1'b0;
                if (r_phase) w_m_next = M_IDLE;
            end
            default: w_m_next = M_IDLE;
        endcase
    end

    // Master state register, slot counters, request latch and result capture.
    always_ff @(posedge i_sclk) begin
        if (!i_rst_n) begin
            r_m_state <= M_IDLE;
            r_phase   <= 1'b0;
            r_m_bit   <= 3'd0;
            r_m_byte  <= 8'd0;
            r_m_rw    <= 1'b0;
            r_m_wdata <= 8'd0;
            r_m_rx    <= 8'd0;
            r_rdata   <= 8'd0;
            r_ack_err <= 1'b0;
            r_done    <= 1'b0;
            r_rearm   <= 1'b1;
        end else begin
            r_m_state <= w_m_next;
            r_done    <= 1'b0;
            if (i_address_in == 7'd0) r_rearm <= 1'b1;
            else if (w_req)           r_rearm <= 1'b0;
            if (r_m_state == M_IDLE || r_m_state == M_START) begin
                r_phase <= 1'b0;
                r_m_bit <= 3'd0;
                if (w_req) begin
                    r_m_byte  <= {i_address_in, i_address_r_w};
                    r_m_rw    <= i_address_r_w;
                    r_m_wdata <= i_sdata_in;
                    r_ack_err <= 1'b0;
                end
            end else begin
                r_phase <= ~r_phase;
                if (r_phase) r_m_bit <= (w_m_next != r_m_state) ? 3'd0 : r_m_bit + 3'd1;
                if (r_m_state == M_AACK && r_phase && r_s_sda) r_ack_err <= 1'b1;
                if (r_m_state == M_DATA && r_phase) r_m_rx <= {r_m_rx[6:0], w_sda};
                if (r_m_state == M_STOP && r_phase) begin
                    r_done <= 1'b1;
                    if (r_m_rw && !r_ack_err) r_rdata <= r_m_rx;
                end
            end
        end
    end

    // Slave next state: START/STOP always win, otherwise advance on SCL rising samples.
    always_comb begin
        w_s_next = r_s_state;
        if (w_start) begin
            w_s_next = S_ADDR;
        end else if (w_stop) begin
            w_s_next = S_WAIT;
        end else if (w_rise) begin
            case (r_s_state)
                S_ADDR:  if (r_s_cnt == 3'd7)
                             w_s_next = (w_s_byte[7:1] == SLAVE_ADDR) ? S_AACK : S_WAIT;
                S_AACK:  w_s_next = S_DATA;
                S_DATA:  if (r_s_cnt == 3'd7) w_s_next = S_DACK;
                S_DACK:  w_s_next = S_WAIT;
                default: w_s_next = r_s_state;
            endcase
        end
    end

    // Slave datapath: drive changes only after a rising sample, i.e. while SCL goes low.
    always_ff @(posedge i_sclk) begin
        if (!i_rst_n) begin
            r_s_state <= S_WAIT;
            r_s_sda   <= 1'b1;
            r_s_sr    <= 8'd0;
            r_s_cnt   <= 3'd0;
            r_s_rw    <= 1'b0;
            r_s_tx    <= 8'd0;
            r_s_rdata <= 8'd0;
            r_s_valid <= 1'b0;
            r_scl_q   <= 1'b1;
            r_sda_q   <= 1'b1;
        end else begin
            r_s_state <= w_s_next;
            r_scl_q   <= w_scl;
            r_sda_q   <= w_sda;
            r_s_valid <= 1'b0;
            if (w_start || w_stop) begin
                r_s_cnt <= 3'd0;
                r_s_sda <= 1'b1;
            end else if (w_rise) begin
                case (r_s_state)
                    S_ADDR: begin
                        r_s_sr  <= w_s_byte;
                        r_s_cnt <= r_s_cnt + 3'd1;
                        if (r_s_cnt == 3'd7 && w_s_byte[7:1] == SLAVE_ADDR) begin
                            r_s_sda <= 1'b0;
                            r_s_rw  <= w_s_byte[0];
                        end
                    end
                    S_AACK: begin
                        r_s_cnt <= 3'd0;
                        if (r_s_rw) begin
                            r_s_sda <= i_data_out[7];
                            r_s_tx  <= {i_data_out[6:0], 1'b0};
                        end else begin
                            r_s_sda <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_s_sr  <= w_s_byte;
                        r_s_cnt <= r_s_cnt + 3'd1;
                        if (r_s_cnt == 3'd7) begin
                            r_s_sda <= r_s_rw;       // release for master NACK, or ACK a write
                        end else if (r_s_rw) begin
                            r_s_sda <= r_s_tx[7];
                            r_s_tx  <= {r_s_tx[6:0], 1'b0};
                        end
                    end
                    S_DACK:  r_s_sda <= 1'b1;
                    default: r_s_sda <= 1'b1;
                endcase
            end else if (r_s_state == S_DACK && !w_scl && !r_s_rw) begin
                r_s_rdata <= r_s_sr;
                r_s_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_slave_pair.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_master_slave_pair
//  Brief    : Self-checking bench for the single-byte I2C master/slave pair.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_master_slave_pair;

    localparam logic [6:0] c_saddr = 7'b1011001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] addr = 7'd0;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] dout = 8'd0;
    logic       o_sclk, o_sdata, o_busy, o_done, o_ack_err, o_slave_valid;
    logic [7:0] o_rdata, o_slave_rdata;

    int tests = 0;
    int fails = 0;

    // Reference model state: last byte each side should be holding.
    logic [7:0] m_rdata = 8'd0;
    logic [7:0] m_srdata = 8'd0;

    i2c_master_slave_pair #(.SLAVE_ADDR(c_saddr)) dut (
        .i_sclk        (clk),
        .i_rst_n       (rst_n),
        .i_address_in  (addr),
        .i_address_r_w (rw),
        .i_sdata_in    (wdata),
        .i_data_out    (dout),
        .o_sclk        (o_sclk),
        .o_sdata       (o_sdata),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_ack_err     (o_ack_err),
        .o_rdata       (o_rdata),
        .o_slave_rdata (o_slave_rdata),
        .o_slave_valid (o_slave_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer: monitor the bus bit-by-bit and compare against the protocol's
    // expected serial sequence and end results.
    task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] wd, input logic [7:0] d);
        logic        match;
        logic [31:0] got_v, exp_v;
        int          nbits, exp_nbits, busy_cnt, starts, stops, valids;
        logic        got_done, prev_scl, prev_sda, ack_at_done;
        logic [7:0]  data;
        match = (a == c_saddr);
        @(posedge clk); #1;
        addr = a; rw = r; wdata = wd; dout = d;
        got_v = 0; nbits = 0; busy_cnt = 0; starts = 0; stops = 0; valids = 0;
        got_done = 1'b0; ack_at_done = 1'b0;
        prev_scl = o_sclk; prev_sda = o_sdata;
        for (int n = 0; n < 200 && !got_done; n++) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (o_slave_valid) valids++;
            if (!prev_scl && o_sclk) begin
                got_v = {got_v[30:0], o_sdata};
                nbits++;
            end
            if (prev_scl && o_sclk && prev_sda && !o_sdata) starts++;
            if (prev_scl && o_sclk && !prev_sda && o_sdata) stops++;
            prev_scl = o_sclk; prev_sda = o_sdata;
            if (o_done) begin
                got_done = 1'b1;
                ack_at_done = o_ack_err;
            end
        end
        // Expected bus bits at each SCL rise: addr, r/w, addr-ack, [data, data-ack], STOP high.
        exp_v = {25'd0, a};
        exp_v = {exp_v[30:0], r};
        exp_v = {exp_v[30:0], ~match};
        exp_nbits = 9;
        if (match) begin
            data = r ? d : wd;
            for (int i = 7; i >= 0; i--) exp_v = {exp_v[30:0], data[i]};
            exp_v = {exp_v[30:0], r};
            exp_nbits += 9;
        end
        exp_v = {exp_v[30:0], 1'b0};
        exp_nbits += 1;
        if (match && r)  m_rdata = d;
        if (match && !r) m_srdata = wd;
        check("done_seen", {31'd0, got_done}, 32'd1);
        check("busy_cycles", busy_cnt, match ? 32'd39 : 32'd21);
        check("ack_err", {31'd0, ack_at_done}, {31'd0, ~match});
        check("scl_rises", nbits, exp_nbits);
        check("bus_bits", got_v, exp_v);
        check("start_count", starts, 32'd1);
        check("stop_count", stops, 32'd1);
        check("slave_valid_pulses", valids, (match && !r) ? 32'd1 : 32'd0);
        check("rdata", {24'd0, o_rdata}, {24'd0, m_rdata});
        check("slave_rdata", {24'd0, o_slave_rdata}, {24'd0, m_srdata});
        @(posedge clk); #1;
        addr = 7'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        int         starts_seen, bad;
        logic       prev_busy;
        logic [6:0] ra;
        logic [7:0] rd, rwd;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_sclk", {31'd0, o_sclk}, 32'd1);
        check("rst_sdata", {31'd0, o_sdata}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_outs", {o_done, o_ack_err, o_slave_valid, o_rdata, o_slave_rdata}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle with zero address: bus stays released, no activity
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!o_sclk || !o_sdata || o_busy) bad++;
        end
        check("idle_quiet", bad, 32'd0);

        // Directed transfers
        xfer(c_saddr, 1'b1, 8'h00, 8'hAA);
        xfer(c_saddr, 1'b0, 8'hA5, 8'h00);
        xfer(7'h12,  1'b0, 8'h3C, 8'h00);
        xfer(7'h12,  1'b1, 8'h00, 8'h55);

        // Randomized transfers
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                ra = c_saddr;
            end else begin
                ra = 7'($urandom_range(1, 127));
                if (ra == c_saddr) ra = ra ^ 7'h01;
            end
            rd  = 8'($urandom);
            rwd = 8'($urandom);
            xfer(ra, 1'($urandom_range(0, 1)), rwd, rd);
        end

        // Rearm: held address yields exactly one transfer
        @(posedge clk); #1;
        addr = c_saddr; rw = 1'b0; wdata = 8'h6B;
        starts_seen = 0; prev_busy = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (o_busy && !prev_busy) starts_seen++;
            prev_busy = o_busy;
        end
        m_srdata = 8'h6B;
        check("rearm_single", starts_seen, 32'd1);
        check("rearm_slave_rdata", {24'd0, o_slave_rdata}, {24'd0, m_srdata});
        @(posedge clk); #1;
        addr = 7'd0;
        @(posedge clk); #1;
        addr = c_saddr; wdata = 8'h19;
        starts_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (o_busy && !prev_busy) starts_seen++;
            prev_busy = o_busy;
        end
        m_srdata = 8'h19;
        check("rearm_second", starts_seen, 32'd1);
        check("rearm2_slave_rdata", {24'd0, o_slave_rdata}, {24'd0, m_srdata});
        @(posedge clk); #1;
        addr = 7'd0;
        @(posedge clk); #1;

        // Reset in the middle of the data phase
        addr = c_saddr; rw = 1'b0; wdata = 8'hC3;
        repeat (26) @(posedge clk);
        #1;
        check("mid_busy_before_rst", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0; addr = 7'd0;
        @(posedge clk);
        @(negedge clk);
        m_rdata = 8'd0; m_srdata = 8'd0;
        check("midrst_sclk", {31'd0, o_sclk}, 32'd1);
        check("midrst_sdata", {31'd0, o_sdata}, 32'd1);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_outs", {o_done, o_ack_err, o_slave_valid, o_rdata, o_slave_rdata}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Link still works after the abort
        xfer(c_saddr, 1'b1, 8'h00, 8'h81);
        xfer(c_saddr, 1'b0, 8'h7E, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
